pipe_ctrl_unit: RTL and testbench
=================================

PIPE_CTRL_UNIT -- requirements
Module: pipe_ctrl_unit

Interface
REQ-001 The block SHALL have parameter DRAIN_CYCLES, default 4, range 1..15: cycles of bubbles issued after HALT acceptance before Halted.
REQ-002 The block SHALL have parameter EN_AUIPC, default 1: when 1, opcode 0010111 decodes as AUIPC; when 0, it is illegal.
REQ-003 One clock; reset is synchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 Opcode  in  7  opcode of instruction in ID.
REQ-007 IdValid  in  1  ID holds a real instruction.
REQ-008 IdRs1, IdRs2  in  5 each  ID source registers.
REQ-009 ExRd  in  5  destination register of instruction in EX.
REQ-010 BranchTaken  in  1  EX resolved taken branch/jump; flush request.
REQ-011 ExALUSrc, ExMemtoReg, ExRegWrite, ExMemRead, ExMemWrite, ExBranch, ExJump, ExJumpReg, ExAuipc  out  1 each  registered control bundle for EX.
REQ-012 ExALUOp  out  2  registered; 00 load/store/AUIPC/JAL, 01 branch, 10 R/I-type, 11 JALR/LUI.
REQ-013 ExValid  out  1  EX bundle is a real instruction.
REQ-014 ExIllegal  out  1  one-cycle registered flag: illegal opcode accepted from ID.
REQ-015 Stall  out  1  combinational; hold PC and IF/ID register.
REQ-016 Flush  out  1  combinational; clear IF/ID register.
REQ-017 Halted  out  1  registered; core stopped.

Function
REQ-018 Decode SHALL be combinational: R 0110011, LOAD 0000011, STORE 0100011, BR 1100011, I 0010011, LUI 0110111, JAL 1101111, JALR 1100111, HALT 1111111, AUIPC 0010111.
REQ-019 ALUSrc=LOAD|STORE|I|JALR|LUI|AUIPC; MemtoReg=MemRead=LOAD; MemWrite=STORE; RegWrite=R|LOAD|I|LUI|JAL|JALR|AUIPC; Branch=BR; Jump=JAL|JALR; JumpReg=JALR.
REQ-020 Rs1 is used by R, I, LOAD, STORE, BR, JALR; Rs2 is used by R, STORE, BR.
REQ-021 Load-use hazard = IdValid & ExValid & ExMemRead & ExRd!=0 & ((rs1 used & ExRd==IdRs1) | (rs2 used & ExRd==IdRs2)).
REQ-022 Priority each cycle: Halted/DRAIN > BranchTaken > load-use > normal issue.
REQ-023 BranchTaken (in RUN): Flush=1, Stall=0, next EX bundle = bubble (all zero); hazard ignored.
REQ-024 Load-use (in RUN, no BranchTaken): Stall=1, Flush=0, next EX bundle = bubble; ID instruction reissued next cycle.
REQ-025 Normal issue: next EX bundle = decoded ID controls, ExValid=IdValid; !IdValid issues a bubble.
REQ-026 Illegal opcode issued: bundle all zero, ExValid=0, ExIllegal=1 for one cycle; it SHALL NOT stall or halt.
REQ-027 Bubble SHALL mean all Ex* outputs 0, ExALUOp=00.
REQ-028 FSM states RUN, DRAIN, HALTED; reset -> RUN.
REQ-029 RUN->DRAIN when HALT issued under normal issue (not flushed, not stalled); EX gets a bubble; counter loads DRAIN_CYCLES-1.
REQ-030 DRAIN: Stall=1, Flush=1, bubbles issued, BranchTaken ignored; counter decrements each cycle; at 0 -> HALTED.
REQ-031 HALTED: Stall=1, Flush=1, bubbles, Halted=1; exit only via reset.
REQ-032 Halted SHALL rise exactly DRAIN_CYCLES+1 cycles after the edge that accepts HALT.
REQ-033 Latency ID decode -> Ex* outputs: one clock.

Reset
REQ-034 While reset=0 at a clk edge: state RUN, counter 0, all Ex* outputs 0, ExIllegal=0, Halted=0.
REQ-035 Reset during DRAIN or HALTED SHALL return to RUN on the next edge with no residual stall.

Structure
REQ-036 Package ctrl_pkg SHALL hold opcode constants, ALUOp encodings, the ctrl_bundle_t struct, and the halt_state_t enum.
REQ-037 Decoding SHALL be a combinational sub-module ctrl_decode (Opcode, EN_AUIPC -> ctrl_bundle_t, illegal, rs1/rs2 used).

Verification
REQ-038 Opcode=0110011, IdValid=1 -> next cycle ExRegWrite=1, ExALUOp=10, ExALUSrc=0, ExValid=1.
REQ-039 EX LOAD ExRd=5, ID R-type IdRs2=5 -> Stall=1 one cycle, EX bubble, R-type issued the following cycle.
REQ-040 Same as REQ-039 with BranchTaken=1 -> Flush=1, Stall=0, EX bubble.
REQ-041 HALT issued with DRAIN_CYCLES=4 -> Stall=Flush=1 from next cycle; Halted=1 on the 5th edge after acceptance; BranchTaken pulse in DRAIN has no effect.
REQ-042 Opcode=0010111 with EN_AUIPC=0 -> ExIllegal=1 one cycle, ExValid=0; with EN_AUIPC=1 -> ExAuipc=1, ExALUSrc=1, ExRegWrite=1.
REQ-043 reset=0 for one edge while HALTED -> Halted=0, Stall=0, state RUN on the next cycle.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared opcode map, ALUOp encodings, EX control bundle and halt FSM states
// for the pipeline control unit.
package ctrl_pkg;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_HALT  = 7'b1111111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;  // load/store/AUIPC/JAL
   localparam logic [1:0] ALUOP_BR    = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;  // R/I-type, funct fields decide
   localparam logic [1:0] ALUOP_PASS  = 2'b11;  // JALR/LUI

   typedef struct packed {
      logic       alu_src;
      logic       mem_to_reg;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic       jump;
      logic       jump_reg;
      logic       auipc;
      logic [1:0] alu_op;
   } ctrl_bundle_t;

   localparam ctrl_bundle_t BUBBLE = '0;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } halt_state_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: control bundle, illegal flag, HALT detect
// and which source registers the instruction actually reads.
module ctrl_decode
   import ctrl_pkg::*;
#(
   parameter bit EN_AUIPC = 1'b1
) (
   input  logic [6:0]   opcode,
   output ctrl_bundle_t ctrl,
   output logic         illegal,
   output logic         is_halt,
   output logic         rs1_used,
   output logic         rs2_used
);

   always_comb begin
      // NOTE: every output gets a default before the case so no path infers a latch.
      ctrl     = BUBBLE;
      illegal  = 1'b0;
      is_halt  = 1'b0;
      rs1_used = 1'b0;
      rs2_used = 1'b0;
      case (opcode)
         OP_R: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = ALUOP_FUNCT;
            rs1_used       = 1'b1;
            rs2_used       = 1'b1;
         end
         OP_LOAD: begin
            ctrl.alu_src    = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.reg_write  = 1'b1;
            ctrl.mem_read   = 1'b1;
            ctrl.alu_op     = ALUOP_ADD;
            rs1_used        = 1'b1;
         end
         OP_STORE: begin
            ctrl.alu_src   = 1'b1;
            ctrl.mem_write = 1'b1;
            ctrl.alu_op    = ALUOP_ADD;
            rs1_used       = 1'b1;
            rs2_used       = 1'b1;
         end
         OP_BR: begin
            ctrl.branch = 1'b1;
            ctrl.alu_op = ALUOP_BR;
            rs1_used    = 1'b1;
            rs2_used    = 1'b1;
         end
         OP_I: begin
            ctrl.alu_src   = 1'b1;
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = ALUOP_FUNCT;
            rs1_used       = 1'b1;
         end
         OP_LUI: begin
            ctrl.alu_src   = 1'b1;
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = ALUOP_PASS;
         end
         OP_JAL: begin
            ctrl.reg_write = 1'b1;
            ctrl.jump      = 1'b1;
            ctrl.alu_op    = ALUOP_ADD;
         end
         OP_JALR: begin
            ctrl.alu_src   = 1'b1;
            ctrl.reg_write = 1'b1;
            ctrl.jump      = 1'b1;
            ctrl.jump_reg  = 1'b1;
            ctrl.alu_op    = ALUOP_PASS;
            rs1_used       = 1'b1;
         end
         OP_AUIPC: begin
            if (EN_AUIPC) begin
               ctrl.alu_src   = 1'b1;
               ctrl.reg_write = 1'b1;
               ctrl.auipc     = 1'b1;
               ctrl.alu_op    = ALUOP_ADD;
            end else begin
               illegal = 1'b1;
            end
         end
         OP_HALT: is_halt = 1'b1;
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control: decodes ID, registers the EX control bundle, resolves
// flush/load-use stalls and sequences HALT through a drain period.
module pipe_ctrl_unit
   import ctrl_pkg::*;
#(
   parameter int unsigned DRAIN_CYCLES = 4,
   parameter bit          EN_AUIPC     = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] Opcode,
   input  logic       IdValid,
   input  logic [4:0] IdRs1,
   input  logic [4:0] IdRs2,
   input  logic [4:0] ExRd,
   input  logic       BranchTaken,
   output logic       ExALUSrc,
   output logic       ExMemtoReg,
   output logic       ExRegWrite,
   output logic       ExMemRead,
   output logic       ExMemWrite,
   output logic       ExBranch,
   output logic       ExJump,
   output logic       ExJumpReg,
   output logic       ExAuipc,
   output logic [1:0] ExALUOp,
   output logic       ExValid,
   output logic       ExIllegal,
   output logic       Stall,
   output logic       Flush,
   output logic       Halted
);

   localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

   halt_state_t  state, state_nxt;
   logic [3:0]   cnt, cnt_nxt;
   ctrl_bundle_t id_ctrl, ex_ctrl, ex_ctrl_nxt;
   logic         id_illegal, id_is_halt, rs1_used, rs2_used;
   logic         ex_valid, ex_valid_nxt;
   logic         ex_illegal, ex_illegal_nxt;
   logic         load_use;

   ctrl_decode #(
      .EN_AUIPC (EN_AUIPC)
   ) u_decode (
      .opcode   (Opcode),
      .ctrl     (id_ctrl),
      .illegal  (id_illegal),
      .is_halt  (id_is_halt),
      .rs1_used (rs1_used),
      .rs2_used (rs2_used)
   );

   // x0 never carries a loaded value, so a load into x0 cannot create a hazard.
   assign load_use = IdValid && ex_valid && ex_ctrl.mem_read && (ExRd != 5'd0) &&
                     ((rs1_used && (ExRd == IdRs1)) || (rs2_used && (ExRd == IdRs2)));

   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      ex_ctrl_nxt    = BUBBLE;
      ex_valid_nxt   = 1'b0;
      ex_illegal_nxt = 1'b0;
      Stall          = 1'b0;
      Flush          = 1'b0;
      case (state)
         ST_RUN: begin
            if (BranchTaken) begin
               Flush = 1'b1;
            end else if (load_use) begin
               Stall = 1'b1;
            end else if (IdValid) begin
               if (id_illegal) begin
                  ex_illegal_nxt = 1'b1;
               end else if (id_is_halt) begin
                  state_nxt = ST_DRAIN;
                  cnt_nxt   = DRAIN_LOAD;
               end else begin
                  ex_ctrl_nxt  = id_ctrl;
                  ex_valid_nxt = 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            Stall = 1'b1;
            Flush = 1'b1;
            if (cnt == 4'd0) state_nxt = ST_HALTED;
            else             cnt_nxt   = cnt - 4'd1;
         end
         ST_HALTED: begin
            Stall = 1'b1;
            Flush = 1'b1;
         end
         default: state_nxt = ST_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state uses non-blocking assignments; reset is only seen on a clock edge.
      if (!reset) begin
         state      <= ST_RUN;
         cnt        <= 4'd0;
         ex_ctrl    <= BUBBLE;
         ex_valid   <= 1'b0;
         ex_illegal <= 1'b0;
         Halted     <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         ex_ctrl    <= ex_ctrl_nxt;
         ex_valid   <= ex_valid_nxt;
         ex_illegal <= ex_illegal_nxt;
         Halted     <= (state == ST_HALTED);
      end
   end

   assign ExALUSrc   = ex_ctrl.alu_src;
   assign ExMemtoReg = ex_ctrl.mem_to_reg;
   assign ExRegWrite = ex_ctrl.reg_write;
   assign ExMemRead  = ex_ctrl.mem_read;
   assign ExMemWrite = ex_ctrl.mem_write;
   assign ExBranch   = ex_ctrl.branch;
   assign ExJump     = ex_ctrl.jump;
   assign ExJumpReg  = ex_ctrl.jump_reg;
   assign ExAuipc    = ex_ctrl.auipc;
   assign ExALUOp    = ex_ctrl.alu_op;
   assign ExValid    = ex_valid;
   assign ExIllegal  = ex_illegal;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: two instances (AUIPC enabled/disabled),
// expected EX words queued at stimulus time and compared after the edge.
module tb_pipe_ctrl_unit;

   localparam logic [6:0] R_OP   = 7'b0110011;
   localparam logic [6:0] LD_OP  = 7'b0000011;
   localparam logic [6:0] ST_OP  = 7'b0100011;
   localparam logic [6:0] BR_OP  = 7'b1100011;
   localparam logic [6:0] I_OP   = 7'b0010011;
   localparam logic [6:0] LUI_OP = 7'b0110111;
   localparam logic [6:0] JAL_OP = 7'b1101111;
   localparam logic [6:0] JR_OP  = 7'b1100111;
   localparam logic [6:0] HLT_OP = 7'b1111111;
   localparam logic [6:0] AUI_OP = 7'b0010111;
   localparam logic [6:0] BAD_OP = 7'b0000000;
   localparam logic [13:0] HW    = 14'h0001;  // only Halted set

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] Opcode;
   logic       IdValid;
   logic [4:0] IdRs1, IdRs2, ExRd;
   logic       BranchTaken;

   logic       a_alusrc, a_m2r, a_rw, a_mr, a_mw, a_br, a_j, a_jr, a_aui, a_v, a_ill, a_stall, a_flush, a_halt;
   logic [1:0] a_aluop;
   logic       b_alusrc, b_m2r, b_rw, b_mr, b_mw, b_br, b_j, b_jr, b_aui, b_v, b_ill, b_stall, b_flush, b_halt;
   logic [1:0] b_aluop;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [13:0] main;
      logic [13:0] na;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   pipe_ctrl_unit dut (
      .clk(clk), .reset(reset), .Opcode(Opcode), .IdValid(IdValid), .IdRs1(IdRs1), .IdRs2(IdRs2),
      .ExRd(ExRd), .BranchTaken(BranchTaken), .ExALUSrc(a_alusrc), .ExMemtoReg(a_m2r),
      .ExRegWrite(a_rw), .ExMemRead(a_mr), .ExMemWrite(a_mw), .ExBranch(a_br), .ExJump(a_j),
      .ExJumpReg(a_jr), .ExAuipc(a_aui), .ExALUOp(a_aluop), .ExValid(a_v), .ExIllegal(a_ill),
      .Stall(a_stall), .Flush(a_flush), .Halted(a_halt)
   );

   pipe_ctrl_unit #(.DRAIN_CYCLES(4), .EN_AUIPC(1'b0)) dut_na (
      .clk(clk), .reset(reset), .Opcode(Opcode), .IdValid(IdValid), .IdRs1(IdRs1), .IdRs2(IdRs2),
      .ExRd(ExRd), .BranchTaken(BranchTaken), .ExALUSrc(b_alusrc), .ExMemtoReg(b_m2r),
      .ExRegWrite(b_rw), .ExMemRead(b_mr), .ExMemWrite(b_mw), .ExBranch(b_br), .ExJump(b_j),
      .ExJumpReg(b_jr), .ExAuipc(b_aui), .ExALUOp(b_aluop), .ExValid(b_v), .ExIllegal(b_ill),
      .Stall(b_stall), .Flush(b_flush), .Halted(b_halt)
   );

   wire [13:0] word_a = {a_alusrc, a_m2r, a_rw, a_mr, a_mw, a_br, a_j, a_jr, a_aui, a_aluop, a_v, a_ill, a_halt};
   wire [13:0] word_b = {b_alusrc, b_m2r, b_rw, b_mr, b_mw, b_br, b_j, b_jr, b_aui, b_aluop, b_v, b_ill, b_halt};

   // Reference decode table: word layout matches word_a/word_b.
   function automatic logic [13:0] model(input logic [6:0] op, input bit en_auipc, input bit valid);
      logic src, m2r, rw, mr, mw, br, j, jr, aui, v, ill;
      logic [1:0] aop;
      {src, m2r, rw, mr, mw, br, j, jr, aui, v, ill} = '0;
      aop = 2'b00;
      v   = 1'b1;
      case (op)
         R_OP:   begin rw = 1; aop = 2'b10; end
         LD_OP:  begin src = 1; m2r = 1; rw = 1; mr = 1; end
         ST_OP:  begin src = 1; mw = 1; end
         BR_OP:  begin br = 1; aop = 2'b01; end
         I_OP:   begin src = 1; rw = 1; aop = 2'b10; end
         LUI_OP: begin src = 1; rw = 1; aop = 2'b11; end
         JAL_OP: begin rw = 1; j = 1; end
         JR_OP:  begin src = 1; rw = 1; j = 1; jr = 1; aop = 2'b11; end
         AUI_OP: if (en_auipc) begin src = 1; rw = 1; aui = 1; end
                 else begin v = 0; ill = 1; end
         HLT_OP: v = 0;
         default: begin v = 0; ill = 1; end
      endcase
      if (!valid) return 14'h0;
      return {src, m2r, rw, mr, mw, br, j, jr, aui, aop, v, ill, 1'b0};
   endfunction

   task automatic check(input string tag, input logic [13:0] obs, input logic [13:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Inputs are already driven; check Stall/Flush mid-cycle, then the EX word after the edge.
   task automatic cycle(input string tag, input logic es, input logic ef,
                        input logic [13:0] em, input logic [13:0] en);
      exp_t e;
      @(negedge clk);
      check({tag, "/stall"}, 14'(a_stall), 14'(es));
      check({tag, "/flush"}, 14'(a_flush), 14'(ef));
      check({tag, "/stall_na"}, 14'(b_stall), 14'(es));
      check({tag, "/flush_na"}, 14'(b_flush), 14'(ef));
      sb.push_back('{main: em, na: en});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check({tag, "/ex"}, word_a, e.main);
      check({tag, "/ex_na"}, word_b, e.na);
   endtask

   task automatic step(input string tag, input logic [6:0] op, input logic v,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic bt, input logic es, input logic ef,
                       input logic [13:0] em, input logic [13:0] en);
      Opcode = op; IdValid = v; IdRs1 = rs1; IdRs2 = rs2; ExRd = rd; BranchTaken = bt;
      cycle(tag, es, ef, em, en);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [6:0] ops [9];
      ops = '{R_OP, LD_OP, ST_OP, BR_OP, I_OP, LUI_OP, JAL_OP, JR_OP, AUI_OP};

      reset = 1'b0; Opcode = R_OP; IdValid = 1'b1; IdRs1 = 5'd0; IdRs2 = 5'd0; ExRd = 5'd0; BranchTaken = 1'b0;
      @(posedge clk); #1;
      cycle("reset", 1'b0, 1'b0, 14'h0, 14'h0);
      reset = 1'b1;

      step("rtype", R_OP, 1, 5'd1, 5'd2, 5'd0, 0, 0, 0, model(R_OP, 1, 1), model(R_OP, 0, 1));
      foreach (ops[i])
         step($sformatf("dec%0d", i), ops[i], 1, 5'(i + 1), 5'(i + 2), 5'd0, 0, 0, 0,
              model(ops[i], 1, 1), model(ops[i], 0, 1));
      step("idle", R_OP, 0, 5'd1, 5'd2, 5'd0, 0, 0, 0, 14'h0, 14'h0);

      // load-use on rs2, then the held R-type issues
      step("ld1", LD_OP, 1, 5'd1, 5'd0, 5'd0, 0, 0, 0, model(LD_OP, 1, 1), model(LD_OP, 0, 1));
      step("lu_rs2", R_OP, 1, 5'd3, 5'd5, 5'd5, 0, 1, 0, 14'h0, 14'h0);
      step("lu_reissue", R_OP, 1, 5'd3, 5'd5, 5'd5, 0, 0, 0, model(R_OP, 1, 1), model(R_OP, 0, 1));
      step("ld2", LD_OP, 1, 5'd1, 5'd0, 5'd0, 0, 0, 0, model(LD_OP, 1, 1), model(LD_OP, 0, 1));
      step("lu_rs1", ST_OP, 1, 5'd5, 5'd7, 5'd5, 0, 1, 0, 14'h0, 14'h0);
      step("lu_st_go", ST_OP, 1, 5'd5, 5'd7, 5'd5, 0, 0, 0, model(ST_OP, 1, 1), model(ST_OP, 0, 1));
      step("ld3", LD_OP, 1, 5'd1, 5'd0, 5'd0, 0, 0, 0, model(LD_OP, 1, 1), model(LD_OP, 0, 1));
      step("rs2_unused", I_OP, 1, 5'd3, 5'd5, 5'd5, 0, 0, 0, model(I_OP, 1, 1), model(I_OP, 0, 1));
      step("ld4", LD_OP, 1, 5'd1, 5'd0, 5'd0, 0, 0, 0, model(LD_OP, 1, 1), model(LD_OP, 0, 1));
      step("rd_x0", R_OP, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, model(R_OP, 1, 1), model(R_OP, 0, 1));

      // taken branch outranks the load-use hazard
      step("ld5", LD_OP, 1, 5'd1, 5'd0, 5'd0, 0, 0, 0, model(LD_OP, 1, 1), model(LD_OP, 0, 1));
      step("bt_hazard", R_OP, 1, 5'd3, 5'd5, 5'd5, 1, 0, 1, 14'h0, 14'h0);
      step("after_bt", R_OP, 1, 5'd3, 5'd5, 5'd5, 0, 0, 0, model(R_OP, 1, 1), model(R_OP, 0, 1));

      step("illegal", BAD_OP, 1, 5'd1, 5'd2, 5'd0, 0, 0, 0, model(BAD_OP, 1, 1), model(BAD_OP, 0, 1));
      step("ill_clear", R_OP, 0, 5'd1, 5'd2, 5'd0, 0, 0, 0, 14'h0, 14'h0);

      // reset in the middle of a drain
      step("halt_a", HLT_OP, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 14'h0, 14'h0);
      step("drain_a", R_OP, 1, 5'd1, 5'd2, 5'd0, 0, 1, 1, 14'h0, 14'h0);
      reset = 1'b0;
      cycle("rst_drain", 1, 1, 14'h0, 14'h0);
      reset = 1'b1;
      step("post_rst_drain", R_OP, 1, 5'd1, 5'd2, 5'd0, 0, 0, 0, model(R_OP, 1, 1), model(R_OP, 0, 1));

      // full halt: Halted on the 5th edge after acceptance, branch pulse ignored
      step("halt_b", HLT_OP, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 14'h0, 14'h0);
      for (int k = 1; k <= 5; k++)
         step($sformatf("drain%0d", k), R_OP, 1, 5'd1, 5'd2, 5'd0, (k == 2), 1, 1,
              (k == 5) ? HW : 14'h0, (k == 5) ? HW : 14'h0);
      step("halted_hold", R_OP, 1, 5'd1, 5'd2, 5'd0, 1, 1, 1, HW, HW);
      reset = 1'b0;
      cycle("rst_halted", 1, 1, 14'h0, 14'h0);
      reset = 1'b1;
      step("after_rst", R_OP, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 14'h0, 14'h0);
      step("resume", JAL_OP, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, model(JAL_OP, 1, 1), model(JAL_OP, 0, 1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
